// File: rtl/wb_arbiter_pkg.sv
// Shared constants and entry layout for the writeback arbiter.
// An entry packs {isFloat, wa[4:0], wd[31:0]} = 38 bits.
package wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic              isFloat;
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: circular buffer of writeback entries.
// Ports:
//   clock, reset     - clock, async active-low reset (empties the buffer)
//   push, pushEntry  - enqueue at the tail (caller guarantees not full)
//   pop              - dequeue the head (caller guarantees not empty)
//   head             - entry at the read pointer
//   count            - occupancy, 0..DEPTH
//   entries, entryVld - whole storage plus per-slot valid, for hazard compare
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             pushEntry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CW-1:0]         count,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      entryVld
);

  logic [PW-1:0] wrPtr, rdPtr;

  assign head = entries[rdPtr];

  // Storage needs no reset: entryVld gates every consumer.
  always_ff @(posedge clock) begin
    if (push) entries[wrPtr] <= pushEntry;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      entryVld <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      // With 0 < count < DEPTH the two pointers differ, so a simultaneous
      // set/clear never hits the same slot.
      if (pop)  entryVld[rdPtr] <= 1'b0;
      if (push) entryVld[wrPtr] <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges in-order pipeline writebacks and buffered multi-cycle
// results onto the single register-file write port.
// Ports:
//   clock, reset                       - clock, async active-low reset
//   pipe_wen/wa/wd/float               - pipeline writeback (never stalls, always wins)
//   mc_valid/ready/wa/wd/float         - multi-cycle result handshake
//   wen/wa/wd/floatingWB               - register-file write port
//   raA/raB/rdD/floatingID             - decode registers to hazard-check
//   hazard_a/b/d                       - register has a buffered, unwritten result
//   stall_req                          - FIFO starved too long, pipeline should yield
//   pending                            - FIFO occupancy
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int CW           = $clog2(DEPTH+1),
  localparam int SW           = $clog2(STARVE_LIMIT+1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_wen,
  input  logic [REG_AW-1:0] pipe_wa,
  input  logic [XLEN-1:0]   pipe_wd,
  input  logic              pipe_float,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_wa,
  input  logic [XLEN-1:0]   mc_wd,
  input  logic              mc_float,
  output logic              wen,
  output logic [REG_AW-1:0] wa,
  output logic [XLEN-1:0]   wd,
  output logic              floatingWB,
  input  logic [REG_AW-1:0] raA,
  input  logic [REG_AW-1:0] raB,
  input  logic [REG_AW-1:0] rdD,
  input  logic              floatingID,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              hazard_d,
  output logic              stall_req,
  output logic [CW-1:0]     pending
);

  wb_entry_t             head, pushEntry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      entryVld;
  logic                  accept, push, pop, starved;
  logic [SW-1:0]         starveCnt;

  // No pop-through when full: ready depends only on the registered count.
  assign mc_ready  = (pending < CW'(DEPTH));
  assign accept    = mc_valid && mc_ready;
  // Integer r0 writes are architecturally dead: consume without buffering.
  assign push      = accept && !(mc_wa == '0 && !mc_float);
  assign pop       = !pipe_wen && (pending != '0);
  assign pushEntry = '{isFloat: mc_float, wa: mc_wa, wd: mc_wd};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .head      (head),
    .count     (pending),
    .entries   (entries),
    .entryVld  (entryVld)
  );

  // Write-port mux: pipeline first, then FIFO head, else all zero.
  always_comb begin
    wen        = 1'b0;
    wa         = '0;
    wd         = '0;
    floatingWB = 1'b0;
    if (pipe_wen) begin
      wen        = 1'b1;
      wa         = pipe_wa;
      wd         = pipe_wd;
      floatingWB = pipe_float;
    end else if (pending != '0) begin
      wen        = 1'b1;
      wa         = head.wa;
      wd         = head.wd;
      floatingWB = head.isFloat;
    end
  end

  // Per-entry compares; the head being drained this cycle still counts,
  // which costs at most one extra stall but avoids a same-cycle bypass.
  logic [DEPTH-1:0] hitA, hitB, hitD;
  for (genvar i = 0; i < DEPTH; i++) begin : g_haz
    logic bankOk;
    assign bankOk  = entryVld[i] && (entries[i].isFloat == floatingID);
    assign hitA[i] = bankOk && (entries[i].wa == raA);
    assign hitB[i] = bankOk && (entries[i].wa == raB);
    assign hitD[i] = bankOk && (entries[i].wa == rdD);
  end
  assign hazard_a = |hitA;
  assign hazard_b = |hitB;
  assign hazard_d = |hitD;

  // Starvation: buffered work that the pipeline keeps pre-empting.
  assign starved = (pending != '0) && !pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
      stall_req <= 1'b0;
    end else begin
      if (!starved)                             starveCnt <= '0;
      else if (starveCnt != SW'(STARVE_LIMIT))  starveCnt <= starveCnt + 1'b1;

      if (pop)                                                  stall_req <= 1'b0;
      else if (starved && starveCnt == SW'(STARVE_LIMIT - 1))   stall_req <= 1'b1;
    end
  end

endmodule
